fp_result_collector: RTL and testbench
======================================

# fp_result_collector

Downstream stage of the FP multiply/divide core. Accepts each result word `R` and its five IEEE-754 exception flags when the core strobes valid, and buffers them in a small in-order FIFO. Results drain to the consumer over a valid/ready handshake. The block also keeps sticky accrued-exception flags (fflags) and a sticky overrun indicator for software/status readout.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `arst` in 1: reset, synchronous, active-low.
- `in_valid` in 1: core result-valid strobe.
- `in_sel` in 1: operation tag (0 = mul, 1 = div), stored with the entry.
- `in_r` in 32: result word (IEEE-754 single).
- `in_flags` in 5: exception flags `{io, dz, of, uf, i}`; bit 4 = io, bit 0 = i.
- `in_ready` out 1: space available.
- `out_valid` out 1: head entry valid.
- `out_r` out 32: head result.
- `out_sel` out 1: head operation tag.
- `out_flags` out 5: head flags.
- `out_ready` in 1: consumer accepts head.
- `fflags` out 5: sticky OR of the flags of all accepted entries since the last clear.
- `fflags_clr` in 1: one-cycle clear of `fflags` and `overrun`.
- `overrun` out 1: sticky; a strobe arrived while full.
- `count` out `$clog2(DEPTH)+1`: current occupancy.

## Operation
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`, decoded from registered state only. `out_valid = (count != 0)`.
- Storage: circular buffer with rd/wr pointers of `$clog2(DEPTH)` bits, wrapping naturally from DEPTH-1 to 0.
- Count update: push only +1; pop only −1; push and pop together leaves it unchanged.
- Full with pop: `in_ready` is still 0, so a push in that cycle is rejected.
- Empty: no bypass, so a push is never popped in the same cycle.
- Ordering: strictly FIFO. `out_r`, `out_sel` and `out_flags` always show the entry at rd pointer.
- Drop: `in_valid && !in_ready` drops the entry. `overrun` is set; `fflags` and storage are unchanged.
- fflags next state: if `fflags_clr`, load the pushed `in_flags` (or 0 with no push); else `fflags | (push ? in_flags : 0)`.
- overrun next state: if `fflags_clr`, it is 0 unless a drop occurs in the same cycle (the drop wins); else `overrun | drop`.
- Flags are accrued at push time, not at pop time.

## Timing
- Reset (`arst` = 0 at a rising edge) sets:
  - `count` = 0 and both pointers = 0;
  - `out_valid` = 0 and `in_ready` = 1;
  - `fflags` = 0 and `overrun` = 0;
  - all storage = 0, so `out_r`, `out_sel` and `out_flags` read 0.
- Reset mid-operation discards all entries. Reset has priority over push, pop and clear.
- Latency: an entry pushed at edge N gives `out_valid` = 1 after edge N. Its sticky flags are visible in `fflags` after the same edge N.
- Throughput: one push and one pop per cycle sustained when 0 < `count` < DEPTH.
- Holding `out_valid` is not required of the core. The FIFO holds the head stable until it is popped.

## Configuration
- Macro `FP_RES_NAN_CANON_EN`.
- Defined: an accepted `in_r` with exponent 8'hFF and nonzero mantissa is stored as 32'h7FC0_0000. Sign and payload are discarded. Flags are unaffected.
- Undefined: `in_r` is stored verbatim.
- Infinities are never altered.

## Structure
- Package `fp_res_pkg` holds:
  - flag index localparams: `IO_IDX` = 4, `DZ_IDX` = 3, `OF_IDX` = 2, `UF_IDX` = 1, `I_IDX` = 0;
  - `typedef logic [4:0] fp_flags_t`;
  - packed struct `fp_res_entry_t {sel, r, flags}`;
  - constant `CANON_NAN` = 32'h7FC0_0000.
- Sub-module `fp_res_fifo`: generic storage, pointers and count, parameterised by DEPTH and entry type. The top level adds canonicalisation, sticky flags and overrun.

## Test plan
- Reset, then push `in_r` = 32'h3F80_0000, flags 5'b00001, `out_ready` = 0 → next cycle `out_valid` = 1, `out_r` = 3F80_0000, `fflags` = 5'b00001, `count` = 1.
- Push 4 entries (DEPTH = 4), then a fifth with flags 5'b01000 → `in_ready` = 0, `overrun` = 1, `fflags` bit 3 stays 0, `count` = 4. Pop all → the original 4 entries come out in order.
- Simultaneous push and pop at `count` = 2 for 10 cycles → `count` stays 2, output order preserved across pointer wrap.
- Push flags 5'b10000, then `fflags_clr` in the same cycle as a push of 5'b00100 → `fflags` = 5'b00100 and `overrun` = 0.
- With `FP_RES_NAN_CANON_EN`, push 32'hFFC1_2345 → `out_r` = 7FC0_0000. Without it → FFC1_2345. Push 32'h7F80_0000 → unchanged in both builds.
- Assert `arst` low with `count` = 3 → next cycle `count` = 0, `out_valid` = 0, `fflags` = 0, `out_r` = 0.

Source files
------------

// File: rtl/fp_res_pkg.sv
// Shared types for the FP result collector: flag indices, entry layout and NaN helpers.
package fp_res_pkg;

  localparam int IO_IDX = 4;
  localparam int DZ_IDX = 3;
  localparam int OF_IDX = 2;
  localparam int UF_IDX = 1;
  localparam int I_IDX  = 0;

  typedef logic [4:0] fp_flags_t;

  typedef struct packed {
    logic        sel;
    logic [31:0] r;
    fp_flags_t   flags;
  } fp_res_entry_t;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Exponent all ones with a nonzero mantissa; infinities are excluded.
  function automatic logic is_nan(input logic [31:0] r);
    return (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] canon_nan(input logic [31:0] r);
    return is_nan(r) ? CANON_NAN : r;
  endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Generic in-order circular buffer: storage, wrapping rd/wr pointers and occupancy count.
module fp_res_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wr_data,
  output entry_t                 rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers are exactly log2(DEPTH) wide, so +1 wraps from DEPTH-1 to 0 on its own.
  always_ff @(posedge clk) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fp_result_collector.sv
// Buffers FP mul/div results in a FIFO and keeps sticky fflags and overrun status.
// Optional build macro FP_RES_NAN_CANON_EN canonicalises stored NaN results.
module fp_result_collector
  import fp_res_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   in_valid,
  input  logic                   in_sel,
  input  logic [31:0]            in_r,
  input  logic [4:0]             in_flags,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [31:0]            out_r,
  output logic                   out_sel,
  output logic [4:0]             out_flags,
  input  logic                   out_ready,
  output logic [4:0]             fflags,
  input  logic                   fflags_clr,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: a transfer happens on any edge where valid && ready. The producer
  // side never stalls the core; a strobe seen with in_ready low is dropped and
  // flagged as overrun. The consumer side holds the head stable until popped.
  logic          push;
  logic          pop;
  logic          drop;
  fp_res_entry_t wr_entry;
  fp_res_entry_t rd_entry;
  logic [31:0]   stored_r;
  fp_flags_t     push_flags;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && !in_ready;

`ifdef FP_RES_NAN_CANON_EN
  assign stored_r = canon_nan(in_r);
`else
  assign stored_r = in_r;
`endif

  assign wr_entry = '{sel: in_sel, r: stored_r, flags: in_flags};

  fp_res_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fp_res_entry_t)
  ) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (count)
  );

  assign out_r     = rd_entry.r;
  assign out_sel   = rd_entry.sel;
  assign out_flags = rd_entry.flags;

  assign push_flags = push ? in_flags : '0;

  // Flags accrue at push time; a clear in the same cycle keeps the new push's flags
  // and a coincident drop still sets overrun.
  always_ff @(posedge clk) begin
    if (!arst) begin
      fflags  <= '0;
      overrun <= 1'b0;
    end else if (fflags_clr) begin
      fflags  <= push_flags;
      overrun <= drop;
    end else begin
      fflags  <= fflags | push_flags;
      overrun <= overrun | drop;
    end
  end

endmodule

// File: tb/tb_fp_result_collector.sv
// Randomised bench for fp_result_collector against a queue-based reference model.
module tb_fp_result_collector;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = 38;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sel = 1'b0;
  logic [31:0]   in_r = '0;
  logic [4:0]    in_flags = '0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_r;
  logic          out_sel;
  logic [4:0]    out_flags;
  logic          out_ready = 1'b0;
  logic [4:0]    fflags;
  logic          fflags_clr = 1'b0;
  logic          overrun;
  logic [CW-1:0] count;

  fp_result_collector #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .arst       (arst),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_r       (in_r),
    .in_flags   (in_flags),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_r      (out_r),
    .out_sel    (out_sel),
    .out_flags  (out_flags),
    .out_ready  (out_ready),
    .fflags     (fflags),
    .fflags_clr (fflags_clr),
    .overrun    (overrun),
    .count      (count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state: expected FIFO contents plus sticky status
  logic [W-1:0] exp_q[$];
  logic [4:0]   exp_fflags;
  logic         exp_overrun;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_store(input logic [31:0] r);
`ifdef FP_RES_NAN_CANON_EN
    if (r[30:23] == 8'hFF && r[22:0] != 0) return 32'h7FC0_0000;
`endif
    return r;
  endfunction

  task automatic check_state();
    check("count", 64'(count), 64'(exp_q.size()));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
    check("fflags", 64'(fflags), 64'(exp_fflags));
    check("overrun", 64'(overrun), 64'(exp_overrun));
    if (exp_q.size() != 0) check("head", 64'({out_sel, out_r, out_flags}), 64'(exp_q[0]));
  endtask

  // Driver: one clock cycle with the given inputs, then model update and check.
  task automatic step(input logic v, input logic s, input logic [31:0] r,
                      input logic [4:0] f, input logic rdy, input logic clr);
    logic do_push, do_pop, do_drop;
    in_valid = v; in_sel = s; in_r = r; in_flags = f; out_ready = rdy; fflags_clr = clr;
    do_push = v && (exp_q.size() < DEPTH);
    do_drop = v && (exp_q.size() == DEPTH);
    do_pop  = rdy && (exp_q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({s, model_store(r), f});
    if (clr) begin
      exp_fflags  = do_push ? f : 5'd0;
      exp_overrun = do_drop;
    end else begin
      exp_fflags  = exp_fflags | (do_push ? f : 5'd0);
      exp_overrun = exp_overrun | do_drop;
    end
    #1;
    check_state();
  endtask

  task automatic do_reset();
    arst = 1'b0; in_valid = 1'b1; in_r = 32'hDEAD_BEEF; in_flags = 5'h1F;
    out_ready = 1'b1; fflags_clr = 1'b0;
    @(posedge clk);
    exp_q.delete(); exp_fflags = '0; exp_overrun = 1'b0;
    #1;
    check_state();
    check("rst_out_r", 64'(out_r), 64'd0);
    check("rst_out_sel", 64'(out_sel), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    arst = 1'b1; in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_r();
    logic [22:0] m;
    m = 23'($urandom);
    case ($urandom_range(0, 3))
      0: return {1'($urandom), 8'hFF, m | 23'd1};
      1: return {1'($urandom), 8'hFF, 23'd0};
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] nan_exp;

  initial begin
    exp_fflags = '0; exp_overrun = 1'b0;
    do_reset();

    // First push becomes visible after one edge
    step(1, 0, 32'h3F80_0000, 5'b00001, 0, 0);
    check("t1_out_r", 64'(out_r), 64'h3F80_0000);
    check("t1_fflags", 64'(fflags), 64'b00001);
    check("t1_count", 64'(count), 64'd1);

    // Fill, then a dropped fifth strobe
    for (int i = 1; i < DEPTH; i++) step(1, 1'(i), 32'h4000_0000 + 32'(i), 5'b00010, 0, 0);
    step(1, 1, 32'h1234_5678, 5'b01000, 0, 0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_overrun", 64'(overrun), 64'd1);
    check("full_fflags_dz", 64'(fflags[3]), 64'd0);
    check("full_count", 64'(count), 64'd4);
    // Pop while full: the concurrent push is rejected
    step(1, 0, 32'hAAAA_AAAA, 5'b10000, 1, 0);
    check("full_pop_count", 64'(count), 64'd3);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 5'b0, 1, 0);
    check("drained_valid", 64'(out_valid), 64'd0);

    // Steady push+pop at count 2 across pointer wrap
    do_reset();
    step(1, 0, 32'h1000_0000, 5'd0, 0, 0);
    step(1, 1, 32'h1000_0001, 5'd0, 0, 0);
    for (int i = 2; i < 12; i++) begin
      step(1, 1'(i), 32'h1000_0000 + 32'(i), 5'd0, 1, 0);
      check("steady_count", 64'(count), 64'd2);
    end

    // Clear coinciding with a push keeps only the new flags
    do_reset();
    step(1, 0, 32'h3F80_0000, 5'b10000, 0, 0);
    step(1, 0, 32'h3F80_0000, 5'b00100, 0, 1);
    check("clr_fflags", 64'(fflags), 64'b00100);
    check("clr_overrun", 64'(overrun), 64'd0);

    // NaN canonicalisation and infinity pass-through
    do_reset();
`ifdef FP_RES_NAN_CANON_EN
    nan_exp = 32'h7FC0_0000;
`else
    nan_exp = 32'hFFC1_2345;
`endif
    step(1, 1, 32'hFFC1_2345, 5'b10000, 0, 0);
    check("nan_r", 64'(out_r), 64'(nan_exp));
    step(1, 0, 32'h7F80_0000, 5'b00100, 1, 0);
    check("inf_r", 64'(out_r), 64'h7F80_0000);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 32'h5000_0000 + 32'(i), 5'b00011, 0, 0);
    check("pre_rst_count", 64'(count), 64'd3);
    do_reset();

    // Randomised traffic with occasional clears, drops and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, 1'($urandom), rand_r(), 5'($urandom_range(0, 31)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
